// File: rtl/riscv_fetch_pkg.sv
// Shared fetch-stage types: FSM states, the bubble instruction and the IF/ID register layout.
// ifid_t is sized by FETCH_PC_W so the decode stage can reuse it without extra parameters.
package riscv_fetch_pkg;

  localparam int          FETCH_PC_W = 9;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    STALLED = 2'd1,
    HALTED  = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic                  valid;
    logic [FETCH_PC_W-1:0] pc;
    logic [31:0]           instr;
  } ifid_t;

  function automatic ifid_t ifid_bubble(input logic [31:0] nop);
    ifid_t b;
    b.valid = 1'b0;
    b.pc    = '0;
    b.instr = nop;
    return b;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding slot for the instruction returned by memory while fetch is stalled.
// Captures on load in one cycle; clear wins over load; no backpressure of its own.
module fetch_skid_buf #(
  parameter int PC_W = 9
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            load,
  input  logic [31:0]     din_instr,
  input  logic [PC_W-1:0] din_pc,
  output logic            full,
  output logic [31:0]     dout_instr,
  output logic [PC_W-1:0] dout_pc
);

  logic            full_q;
  logic [31:0]     instr_q;
  logic [PC_W-1:0] pc_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      full_q <= 1'b0;
    end else if (load) begin
      full_q  <= 1'b1;
      instr_q <= din_instr;
      pc_q    <= din_pc;
    end
  end

  assign full       = full_q;
  assign dout_instr = instr_q;
  assign dout_pc    = pc_q;

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, reads a 1-cycle synchronous imem and fills IF/ID.
// PC-to-IF/ID latency 2 cycles; stall holds PC and IF/ID, the in-flight word parks in the skid.
module if_fetch_unit #(
  parameter int          PC_W      = riscv_fetch_pkg::FETCH_PC_W,
  parameter logic [31:0] NOP_INSTR = riscv_fetch_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            pc_sel,
  input  logic [31:0]     br_pc,
  input  logic            halt_req,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_rd_en,
  input  logic [31:0]     imem_rdata,
  output logic            ifid_valid,
  output logic [PC_W-1:0] ifid_pc,
  output logic [31:0]     ifid_instr,
  output logic            halted,
  output logic            misalign_err
);

  import riscv_fetch_pkg::*;

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  fetch_state_e    state_q;
  logic [PC_W-1:0] pc_q;
  logic            inflight_q;
  logic [PC_W-1:0] inflight_pc_q;
  ifid_t           ifid_q;
  logic            misalign_q;

  logic            skid_load;
  logic            skid_clear;
  logic            skid_full;
  logic [31:0]     skid_instr;
  logic [PC_W-1:0] skid_pc;
  logic            active;
  logic            unused_br_hi;

  assign unused_br_hi = ^br_pc[31:PC_W];
  assign active       = (state_q != HALTED);

  // Only the first stall cycle sees the word for inflight_pc on imem_rdata.
  assign skid_load  = !reset && (state_q == RUN) && stall && !pc_sel && !halt_req && inflight_q;
  assign skid_clear = reset || (active && (pc_sel || halt_req || (state_q == STALLED && !stall)));

  fetch_skid_buf #(.PC_W(PC_W)) u_skid (
    .clk        (clk),
    .clear      (skid_clear),
    .load       (skid_load),
    .din_instr  (imem_rdata),
    .din_pc     (inflight_pc_q),
    .full       (skid_full),
    .dout_instr (skid_instr),
    .dout_pc    (skid_pc)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= RUN;
      pc_q          <= '0;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
      ifid_q        <= ifid_bubble(NOP_INSTR);
      misalign_q    <= 1'b0;
    end else if (active) begin
      if (pc_sel) begin
        pc_q       <= {br_pc[PC_W-1:2], 2'b00};
        inflight_q <= 1'b0;
        ifid_q     <= ifid_bubble(NOP_INSTR);
        state_q    <= RUN;
        if (br_pc[1:0] != 2'b00) misalign_q <= 1'b1;
      end else if (halt_req) begin
        ifid_q  <= ifid_bubble(NOP_INSTR);
        state_q <= HALTED;
      end else if (state_q == RUN) begin
        if (stall) begin
          state_q <= STALLED;
        end else begin
          pc_q          <= pc_q + PC_STEP;
          inflight_q    <= 1'b1;
          inflight_pc_q <= pc_q;
          ifid_q.valid  <= inflight_q;
          ifid_q.pc     <= inflight_pc_q;
          ifid_q.instr  <= inflight_q ? imem_rdata : NOP_INSTR;
        end
      end else if (!stall) begin
        // Nothing was read during the stall, so the resume cycle has no word in flight.
        inflight_q   <= 1'b0;
        ifid_q.valid <= skid_full;
        ifid_q.pc    <= skid_pc;
        ifid_q.instr <= skid_full ? skid_instr : NOP_INSTR;
        state_q      <= RUN;
      end
    end
  end

  assign imem_addr    = pc_q;
  assign imem_rd_en   = !reset && (state_q == RUN) && !stall;
  assign ifid_valid   = ifid_q.valid;
  assign ifid_pc      = ifid_q.pc;
  assign ifid_instr   = ifid_q.instr;
  assign halted       = (state_q == HALTED);
  assign misalign_err = misalign_q;

endmodule
